pwm_multichannel: RTL and testbench
===================================

Name: pwm_multichannel

Overview:
Parametrised multi-channel PWM generator. One shared frame counter drives NUM_CH independent duty comparators. Supports programmable period, edge- or centre-aligned mode, and per-channel output polarity. Configuration is double-buffered, so updates take effect only at frame boundaries and never produce glitched pulses. It is used wherever the design needs several phase-locked PWM outputs, such as motor or LED drive.

Parameters:
- CNT_W, 8, width of the counter, period and duty values.
- NUM_CH, 4, number of PWM output channels (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable. 0 holds the counter and forces outputs inactive.
- load  in  1  single-cycle strobe that captures period/duty/center_mode/polarity into staging.
- period  in  CNT_W  frame top value P.
- center_mode  in  1  0 = edge-aligned, 1 = centre-aligned.
- duty  in  NUM_CH*CNT_W  per-channel duty; channel i is bits [i*CNT_W +: CNT_W].
- polarity  in  NUM_CH  per-channel output inversion.
- pwm_out  out  NUM_CH  PWM outputs (registered).
- period_start  out  1  one-cycle pulse, aligned with the first output cycle of each frame.
- load_ack  out  1  one-cycle pulse when staged configuration becomes active.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Counter = 0, direction = up, pending = 0.
  - Active and staging config: P = all-ones, duty = 0, edge mode, polarity = 0.
  - pwm_out = 0, period_start = 0, load_ack = 0.
  - Reset mid-frame discards any pending load.
- Edge mode:
  - Counter runs 0,1,…,P then wraps to 0. Frame length is P+1 cycles.
- Centre mode:
  - Counter runs up 0…P, then down P-1…1, then back to 0. Frame length is 2P cycles.
  - If P=0 in centre mode, the counter holds at 0 and the frame length is 1.
- Compare (per channel): raw = (cnt < duty_i).
  - pwm_out_i = raw XOR polarity_i, registered.
  - pwm_out and period_start reflect the counter value of the previous cycle, i.e. 1-cycle latency. Both are aligned to each other.
  - duty = 0 gives 0% (inactive level).
  - duty > maximum counter value gives 100%.
  - Comparison is unsigned and CNT_W wide; no overflow is possible.
- Frame boundary: the cycle in which the counter is 0 while en=1.
  - period_start is asserted on the following cycle, together with the first output of that frame.
- Load/shadow:
  - A load strobe overwrites staging and sets pending.
  - A repeated load before commit overwrites staging again (last write wins).
  - At a frame boundary with pending set, staging is copied to active, pending clears, and load_ack pulses aligned with that frame's period_start.
  - The new config therefore governs the whole frame; the current frame always completes with the old values.
  - If load coincides with a boundary cycle, that boundary commits the previous staging (if pending). The new load stays pending for the next boundary.
- Disable (en=0):
  - Counter held at 0, direction = up.
  - pwm_out = polarity (inactive level) from the next cycle; period_start = 0.
  - A pending load commits on the next clock; load_ack pulses one cycle after the commit edge.
  - When en rises, the first enabled cycle is a frame boundary.
- Changing P to a value below the current count only ever happens at a boundary, because of shadowing. The counter therefore never runs past the active P.

Decomposition:
- Package pwm_pkg:
  - Mode enum PWM_EDGE = 0, PWM_CENTER = 1.
  - Default CNT_W/NUM_CH constants.
  - Reset-value constants for the active config.
- Sub-module pwm_channel_cmp:
  - Compare, polarity XOR and output register for one channel.
  - Instantiated NUM_CH times via generate.
- Counter, direction, shadow registers and handshake stay in the top level.

Test Plan:
1. Reset check: hold rst 3 cycles with en=1 and load=1 → pwm_out=0000, period_start=0, load_ack=0 throughout. After release with no load, all outputs stay 0 (duty 0).
2. Edge mode: load P=9, duty = {5,10,0,3} (ch3..ch0), en=1.
   - period_start every 10 cycles.
   - Per frame: ch0 high 3 cycles, ch1 always low, ch2 always high, ch3 high 5 cycles.
   - All high cycles start at period_start.
3. Centre mode: P=4, duty0=2 → 8-cycle frame with counter 0,1,2,3,4,3,2,1. ch0 high at counts 0,1 and the trailing 1, i.e. 3 cycles per frame, symmetric about the wrap.
4. Shadow update: in edge mode P=9 with duty0=3, pulse load with duty0=7 at frame cycle 4.
   - The current frame still shows 3 high cycles.
   - load_ack and period_start coincide on the next frame, which shows 7 high cycles.
   - A second load at a boundary cycle commits one frame later.
5. Polarity/disable: polarity0=1, duty0=3, P=9 → ch0 low 3 and high 7 per frame. Drop en → next cycle pwm_out = 0001, period_start stays 0. Raise en → period_start one cycle later and the frame restarts from count 0.
6. Reset mid-frame with load pending → on the next cycle all outputs are at reset values and pending is discarded (no load_ack). After re-enable, the reset config is used.

Source files
------------

// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_pkg
//  Description : Shared types and constants for the multi-channel PWM block:
//                alignment mode and count direction encodings, default
//                sizing and reset values of the active/staging configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        PWM_DIR_UP   = 1'b0,
        PWM_DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int PWM_CNT_W_DEF  = 8;
    localparam int PWM_NUM_CH_DEF = 4;

    // Reset configuration: period all-ones, duty 0, edge mode, polarity 0.
    localparam logic      PWM_RST_PERIOD_BIT = 1'b1;
    localparam logic      PWM_RST_DUTY_BIT   = 1'b0;
    localparam logic      PWM_RST_POL_BIT    = 1'b0;
    localparam pwm_mode_e PWM_RST_MODE       = PWM_EDGE;

endpackage
`default_nettype wire

// File: rtl/pwm_channel_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel_cmp
//  Description : One PWM channel: unsigned count/duty compare, polarity
//                inversion and output register.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_en          - run enable; 0 drives the inactive level
//                i_cnt         - shared frame counter value
//                i_duty        - effective duty for this cycle
//                i_polarity    - effective output inversion for this cycle
//                o_pwm_out     - registered PWM output
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_duty,
    input  logic             i_polarity,
    output logic             o_pwm_out
);

    logic pwm_out_d;
    logic pwm_out_q;

    always_comb begin
        pwm_out_d = i_polarity;
        if (i_en) begin
            pwm_out_d = (i_cnt < i_duty) ^ i_polarity;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out_q <= 1'b0;
        end else begin
            pwm_out_q <= pwm_out_d;
        end
    end

    assign o_pwm_out = pwm_out_q;

endmodule
`default_nettype wire

// File: rtl/pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_multichannel
//  Description : Multi-channel PWM generator with one shared frame counter,
//                edge/centre alignment, per-channel polarity and a
//                double-buffered configuration committed at frame boundaries.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                en            - run enable (0 holds counter, outputs inactive)
//                load          - strobe capturing config into staging
//                period        - frame top value
//                center_mode   - 0 edge-aligned, 1 centre-aligned
//                duty          - packed per-channel duty (CNT_W per channel)
//                polarity      - per-channel output inversion
//                pwm_out       - registered PWM outputs
//                period_start  - pulse with the first output of each frame
//                load_ack      - pulse when staged config becomes active
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int CNT_W  = PWM_CNT_W_DEF,
    parameter int NUM_CH = PWM_NUM_CH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [CNT_W-1:0]        period,
    input  logic                    center_mode,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic [NUM_CH-1:0]       polarity,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start,
    output logic                    load_ack
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    // Counter and direction
    logic [CNT_W-1:0] cnt_d, cnt_q;
    pwm_dir_e         dir_d, dir_q;

    // Staging and active configuration
    logic                    pending_d, pending_q;
    logic [CNT_W-1:0]        stg_period_d, stg_period_q;
    pwm_mode_e               stg_mode_d, stg_mode_q;
    logic [NUM_CH*CNT_W-1:0] stg_duty_d, stg_duty_q;
    logic [NUM_CH-1:0]       stg_pol_d, stg_pol_q;
    logic [CNT_W-1:0]        act_period_d, act_period_q;
    pwm_mode_e               act_mode_d, act_mode_q;
    logic [NUM_CH*CNT_W-1:0] act_duty_d, act_duty_q;
    logic [NUM_CH-1:0]       act_pol_d, act_pol_q;

    logic period_start_d, period_start_q;
    logic load_ack_d, load_ack_q;

    // Configuration governing the current cycle. On a committing cycle the
    // staged values take over immediately so the whole new frame, including
    // its count-0 cycle, uses them.
    logic                    w_boundary;
    logic                    w_commit;
    logic [CNT_W-1:0]        w_cfg_period;
    pwm_mode_e               w_cfg_mode;
    logic [NUM_CH*CNT_W-1:0] w_cfg_duty;
    logic [NUM_CH-1:0]       w_cfg_pol;
    logic [NUM_CH-1:0]       w_pwm;

    always_comb begin
        w_boundary = en && (cnt_q == '0);
        // While disabled the counter sits at 0, so a pending load commits
        // on the next clock regardless of en.
        w_commit   = pending_q && (!en || (cnt_q == '0));

        w_cfg_period = w_commit ? stg_period_q : act_period_q;
        w_cfg_mode   = w_commit ? stg_mode_q   : act_mode_q;
        w_cfg_duty   = w_commit ? stg_duty_q   : act_duty_q;
        w_cfg_pol    = w_commit ? stg_pol_q    : act_pol_q;
    end

    // Counter sequencing
    always_comb begin
        cnt_d = '0;
        dir_d = PWM_DIR_UP;
        if (en) begin
            if (w_cfg_mode == PWM_EDGE) begin
                cnt_d = (cnt_q >= w_cfg_period) ? '0 : cnt_q + C_ONE;
            end else if (w_cfg_period == '0) begin
                cnt_d = '0;
            end else if (dir_q == PWM_DIR_UP) begin
                if (cnt_q < w_cfg_period) begin
                    cnt_d = cnt_q + C_ONE;
                end else begin
                    // Turn at the top; with P=1 the descent is empty.
                    cnt_d = w_cfg_period - C_ONE;
                    dir_d = (w_cfg_period == C_ONE) ? PWM_DIR_UP : PWM_DIR_DOWN;
                end
            end else begin
                cnt_d = cnt_q - C_ONE;
                dir_d = (cnt_q == C_ONE) ? PWM_DIR_UP : PWM_DIR_DOWN;
            end
        end
    end

    // Shadow registers and handshake
    always_comb begin
        stg_period_d = stg_period_q;
        stg_mode_d   = stg_mode_q;
        stg_duty_d   = stg_duty_q;
        stg_pol_d    = stg_pol_q;
        pending_d    = pending_q && !w_commit;
        if (load) begin
            // A load coinciding with a commit stays pending for the next one.
            stg_period_d = period;
            stg_mode_d   = pwm_mode_e'(center_mode);
            stg_duty_d   = duty;
            stg_pol_d    = polarity;
            pending_d    = 1'b1;
        end

        act_period_d   = w_cfg_period;
        act_mode_d     = w_cfg_mode;
        act_duty_d     = w_cfg_duty;
        act_pol_d      = w_cfg_pol;

        period_start_d = w_boundary;
        load_ack_d     = w_commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            dir_q          <= PWM_DIR_UP;
            pending_q      <= 1'b0;
            stg_period_q   <= {CNT_W{PWM_RST_PERIOD_BIT}};
            stg_mode_q     <= PWM_RST_MODE;
            stg_duty_q     <= {(NUM_CH*CNT_W){PWM_RST_DUTY_BIT}};
            stg_pol_q      <= {NUM_CH{PWM_RST_POL_BIT}};
            act_period_q   <= {CNT_W{PWM_RST_PERIOD_BIT}};
            act_mode_q     <= PWM_RST_MODE;
            act_duty_q     <= {(NUM_CH*CNT_W){PWM_RST_DUTY_BIT}};
            act_pol_q      <= {NUM_CH{PWM_RST_POL_BIT}};
            period_start_q <= 1'b0;
            load_ack_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            pending_q      <= pending_d;
            stg_period_q   <= stg_period_d;
            stg_mode_q     <= stg_mode_d;
            stg_duty_q     <= stg_duty_d;
            stg_pol_q      <= stg_pol_d;
            act_period_q   <= act_period_d;
            act_mode_q     <= act_mode_d;
            act_duty_q     <= act_duty_d;
            act_pol_q      <= act_pol_d;
            period_start_q <= period_start_d;
            load_ack_q     <= load_ack_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            pwm_channel_cmp #(
                .CNT_W (CNT_W)
            ) u_cmp (
                .clk        (clk),
                .rst        (rst),
                .i_en       (en),
                .i_cnt      (cnt_q),
                .i_duty     (w_cfg_duty[i*CNT_W +: CNT_W]),
                .i_polarity (w_cfg_pol[i]),
                .o_pwm_out  (w_pwm[i])
            );
        end
    endgenerate

    assign pwm_out      = w_pwm;
    assign period_start = period_start_q;
    assign load_ack     = load_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multichannel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multichannel
//  Description : Self-checking bench for pwm_multichannel. A frame-position
//                reference model predicts every output each cycle; directed
//                scenarios add explicit per-frame pulse-count checks, then a
//                randomized phase exercises load, enable and reset mixes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multichannel;

    localparam int CNT_W  = 8;
    localparam int NUM_CH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    load;
    logic [CNT_W-1:0]        period;
    logic                    center_mode;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [NUM_CH-1:0]       polarity;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    period_start;
    logic                    load_ack;

    pwm_multichannel #(
        .CNT_W  (CNT_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .load         (load),
        .period       (period),
        .center_mode  (center_mode),
        .duty         (duty),
        .polarity     (polarity),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .load_ack     (load_ack)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic [CNT_W-1:0]        p;
        logic                    c;
        logic [NUM_CH*CNT_W-1:0] d;
        logic [NUM_CH-1:0]       pol;
    } cfg_t;

    cfg_t              m_act, m_stg;
    bit                m_pending;
    int                m_k;          // position within the current frame
    logic [NUM_CH-1:0] exp_pwm;
    logic              exp_ps, exp_ack;

    int n_checks = 0;
    int n_fail   = 0;
    int hi [NUM_CH];
    int ps_n, ack_n;

    function automatic cfg_t rst_cfg();
        cfg_t c;
        c.p = '1; c.c = 1'b0; c.d = '0; c.pol = '0;
        return c;
    endfunction

    function automatic int frame_len(cfg_t c);
        if (!c.c)     return int'(c.p) + 1;
        if (c.p == 0) return 1;
        return 2 * int'(c.p);
    endfunction

    // Counter value at frame position k: ramp in edge mode, triangle in
    // centre mode.
    function automatic int cnt_at(cfg_t c, int k);
        if (!c.c || k <= int'(c.p)) return k;
        return 2 * int'(c.p) - k;
    endfunction

    task automatic model_step();
        cfg_t cur;
        bit   commit;
        int   c;
        if (rst) begin
            m_act = rst_cfg(); m_stg = rst_cfg(); m_pending = 0; m_k = 0;
            exp_pwm = '0; exp_ps = 0; exp_ack = 0;
        end else begin
            commit = m_pending && (!en || m_k == 0);
            cur    = commit ? m_stg : m_act;
            if (en) begin
                c = cnt_at(cur, m_k);
                for (int i = 0; i < NUM_CH; i++)
                    exp_pwm[i] = (c < int'(cur.d[i*CNT_W +: CNT_W])) ^ cur.pol[i];
                exp_ps = (m_k == 0);
                m_k    = (m_k + 1) % frame_len(cur);
            end else begin
                exp_pwm = cur.pol;
                exp_ps  = 0;
                m_k     = 0;
            end
            exp_ack = commit;
            m_act   = cur;
            if (load) begin
                m_stg.p = period; m_stg.c = center_mode;
                m_stg.d = duty;   m_stg.pol = polarity;
                m_pending = 1;
            end else if (commit) begin
                m_pending = 0;
            end
        end
    endtask

    // ------------------------------------------------------------- checking
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
        ps_n = 0; ack_n = 0;
    endtask

    // One clock: model update at the edge, compare 1 time unit later, then
    // return at the falling edge ready for the next input drive.
    task automatic tick(string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ":pwm_out"},      32'(pwm_out),      32'(exp_pwm));
        check({tag, ":period_start"}, 32'(period_start), 32'(exp_ps));
        check({tag, ":load_ack"},     32'(load_ack),     32'(exp_ack));
        for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
        ps_n  += int'(period_start);
        ack_n += int'(load_ack);
        @(negedge clk);
    endtask

    task automatic run(string tag, int n);
        for (int j = 0; j < n; j++) tick(tag);
    endtask

    task automatic do_load(string tag, int p, bit c, logic [NUM_CH*CNT_W-1:0] d,
                           logic [NUM_CH-1:0] pol);
        period = CNT_W'(p); center_mode = c; duty = d; polarity = pol;
        load = 1'b1;
        tick(tag);
        load = 1'b0;
    endtask

    // Advance until the next tick is a frame boundary (bounded by max frame).
    task automatic align(string tag);
        int n = 0;
        while (m_k != 0 && n < 1024) begin
            tick(tag);
            n++;
        end
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1;
        period = 8'd3; center_mode = 1'b0; duty = 32'hFFFF_FFFF; polarity = 4'hF;
        clr_counts();

        // 1. Reset held with en and load high; then idle on reset config.
        run("reset", 3);
        rst = 1'b0; load = 1'b0;
        clr_counts();
        run("post_reset", 20);
        check("post_reset_highs", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);
        check("post_reset_ack", 32'(ack_n), 32'd0);

        // 2. Edge mode P=9, duty {5,10,0,3}.
        do_load("edge_load", 9, 1'b0, {8'd5, 8'd10, 8'd0, 8'd3}, 4'b0000);
        align("edge_align");
        clr_counts();
        run("edge", 20);
        check("edge_ps_cnt",  32'(ps_n),  32'd2);
        check("edge_ch0_hi",  32'(hi[0]), 32'd6);
        check("edge_ch1_hi",  32'(hi[1]), 32'd0);
        check("edge_ch2_hi",  32'(hi[2]), 32'd20);
        check("edge_ch3_hi",  32'(hi[3]), 32'd10);
        check("edge_ack_cnt", 32'(ack_n), 32'd1);

        // 3. Centre mode P=4, duty0=2 -> 8-cycle frame, 3 high cycles.
        do_load("ctr_load", 4, 1'b1, {8'd0, 8'd0, 8'd0, 8'd2}, 4'b0000);
        align("ctr_align");
        clr_counts();
        run("ctr", 16);
        check("ctr_ps_cnt", 32'(ps_n),  32'd2);
        check("ctr_ch0_hi", 32'(hi[0]), 32'd6);

        // 4. Shadow update mid-frame, then a load coinciding with a boundary.
        do_load("sh_load", 9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0000);
        align("sh_align");
        clr_counts();
        run("sh_old", 4);
        do_load("sh_mid", 9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd7}, 4'b0000);
        run("sh_old", 5);
        check("sh_old_ch0_hi", 32'(hi[0]), 32'd3);
        clr_counts();
        run("sh_new", 10);
        check("sh_new_ch0_hi", 32'(hi[0]), 32'd7);
        check("sh_new_ack",    32'(ack_n), 32'd1);
        run("sh_b", 2);
        do_load("sh_b_mid", 9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd5}, 4'b0000);
        run("sh_b", 7);
        clr_counts();
        do_load("sh_b_bnd", 9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd1}, 4'b0000);
        run("sh_b", 9);
        check("sh_b1_ch0_hi", 32'(hi[0]), 32'd5);
        check("sh_b1_ack",    32'(ack_n), 32'd1);
        clr_counts();
        run("sh_b2", 10);
        check("sh_b2_ch0_hi", 32'(hi[0]), 32'd1);
        check("sh_b2_ack",    32'(ack_n), 32'd1);

        // 5. Polarity and disable/re-enable.
        do_load("pol_load", 9, 1'b0, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0001);
        align("pol_align");
        clr_counts();
        run("pol", 10);
        check("pol_ch0_hi", 32'(hi[0]), 32'd7);
        run("pol", 4);
        en = 1'b0;
        tick("dis");
        check("dis_pwm", 32'(pwm_out), 32'h1);
        check("dis_ps",  32'(period_start), 32'd0);
        run("dis", 3);
        en = 1'b1;
        tick("reen");
        check("reen_ps", 32'(period_start), 32'd1);
        run("reen", 12);

        // 6. Reset mid-frame with a pending load.
        do_load("rstp_load", 5, 1'b0, {8'd2, 8'd2, 8'd2, 8'd2}, 4'b1010);
        run("rstp", 2);
        rst = 1'b1;
        tick("rstp_rst");
        check("rstp_pwm", 32'(pwm_out), 32'd0);
        rst = 1'b0;
        clr_counts();
        run("rstp_after", 300);
        check("rstp_no_ack", 32'(ack_n), 32'd0);
        check("rstp_hi0",    32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);
        check("rstp_ps",     32'(ps_n), 32'd2);

        // Randomized phase.
        for (int n = 0; n < 4000; n++) begin
            int p;
            rst  = ($urandom % 600) == 0;
            if (($urandom % 50) == 0) en = ~en;
            load = ($urandom % 20) == 0;
            p    = (($urandom % 8) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 12));
            period      = CNT_W'(p);
            center_mode = 1'($urandom);
            for (int i = 0; i < NUM_CH; i++) begin
                int dv = int'($urandom_range(0, p + 2));
                duty[i*CNT_W +: CNT_W] = CNT_W'((dv > 255) ? 255 : dv);
            end
            polarity = NUM_CH'($urandom);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
